// File: rtl/ofm_packetizer.sv
// Packs channel-parallel pooled pixels into NoC packets: one head flit carrying
// tile and feature-map coordinates, then one flit per channel with the last as tail.
module ofm_packetizer #(
  parameter int         XW       = 4,
  parameter int         QW       = 32,
  parameter logic [3:0] x        = 4'd0,
  parameter logic [3:0] y        = 4'd0,
  parameter logic [3:0] dst_x    = 4'd0,
  parameter logic [3:0] dst_y    = 4'd0,
  parameter int         ofsize_x = 1,
  parameter int         ofsize_y = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [XW-1:0][QW-1:0]  data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [QW+1:0]          flit_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   frame_done_o
);

  localparam int             CW      = (XW > 1) ? $clog2(XW) : 1;
  localparam logic [CW-1:0]  LAST_CH = CW'(XW - 1);
  localparam logic [7:0]     LAST_X  = 8'(ofsize_x - 1);
  localparam logic [7:0]     LAST_Y  = 8'(ofsize_y - 1);

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          chan, chan_nxt;
  logic [XW-1:0][QW-1:0]  hold;
  logic [7:0]             pix_x, pix_y, hdr_x, hdr_y;
  logic                   frame_done;
  logic                   last_ch, tail_hs, accept;
  logic [QW-1:0]          head_pl;

  assign last_ch      = (chan == LAST_CH);
  assign tail_hs      = (state == BODY) & last_ch & ready_i;
  assign ready_o      = rstn & ((state == IDLE) | tail_hs);
  assign accept       = valid_i & ready_o;
  assign frame_done_o = frame_done;

  always_comb begin
    head_pl        = '0;
    head_pl[31:0]  = {hdr_y, hdr_x, y, x, dst_y, dst_x};
  end

  always_comb begin
    state_nxt = state;
    chan_nxt  = chan;
    valid_o   = 1'b0;
    flit_o    = '0;
    case (state)
      IDLE: begin
        if (valid_i) state_nxt = HEAD;
      end
      HEAD: begin
        valid_o = 1'b1;
        flit_o  = {2'b01, head_pl};
        if (ready_i) begin
          state_nxt = BODY;
          chan_nxt  = '0;
        end
      end
      BODY: begin
        valid_o = 1'b1;
        flit_o  = {last_ch ? 2'b11 : 2'b10, hold[chan]};
        if (ready_i) begin
          if (!last_ch) chan_nxt  = chan + 1'b1;
          else          state_nxt = valid_i ? HEAD : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture stage: pixel and its coordinates are latched together on acceptance
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      chan       <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      hdr_x      <= '0;
      hdr_y      <= '0;
      hold       <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      chan       <= chan_nxt;
      frame_done <= tail_hs & (hdr_x == LAST_X) & (hdr_y == LAST_Y);
      if (accept) begin
        hold  <= data_i;
        hdr_x <= pix_x;
        hdr_y <= pix_y;
        if (pix_x == LAST_X) begin
          pix_x <= '0;
          pix_y <= (pix_y == LAST_Y) ? 8'd0 : pix_y + 8'd1;
        end else begin
          pix_x <= pix_x + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ofm_packetizer.sv
// Directed and scoreboarded checks of ofm_packetizer: a 2x2 frame instance for
// directed cases and a 4x3 instance for the random handshake run.
module tb_ofm_packetizer;
  localparam int XW = 4;
  localparam int QW = 32;

  logic                  clk, rstn, valid_i, ready_i;
  logic [XW-1:0][QW-1:0] data_i;
  logic                  ready_o, valid_o, frame_done_o;
  logic [QW+1:0]         flit_o;
  logic                  ready_o2, valid_o2, frame_done_o2;
  logic [QW+1:0]         flit_o2;

  int n_cmp = 0;
  int n_err = 0;

  ofm_packetizer #(.XW(XW), .QW(QW), .x(4'd0), .y(4'd2), .dst_x(4'd3), .dst_y(4'd1),
                   .ofsize_x(2), .ofsize_y(2)) u_dut (
    .clk(clk), .rstn(rstn), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .flit_o(flit_o), .valid_o(valid_o), .ready_i(ready_i), .frame_done_o(frame_done_o));

  ofm_packetizer #(.XW(XW), .QW(QW), .x(4'd0), .y(4'd2), .dst_x(4'd3), .dst_y(4'd1),
                   .ofsize_x(4), .ofsize_y(3)) u_dut2 (
    .clk(clk), .rstn(rstn), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o2),
    .flit_o(flit_o2), .valid_o(valid_o2), .ready_i(ready_i), .frame_done_o(frame_done_o2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fl(input int c);
    case (c)
      0:       fl = 32'h3F80_0000;
      1:       fl = 32'h4000_0000;
      2:       fl = 32'h4040_0000;
      default: fl = 32'h4080_0000;
    endcase
  endfunction

  function automatic logic [31:0] sv(input int p, input int c);
    sv = 32'h4100_0000 + 32'(p * 256 + c);
  endfunction

  function automatic logic [QW+1:0] head_flit(input logic [7:0] px, input logic [7:0] py);
    head_flit = {2'b01, py, px, 16'h2013};
  endfunction

  function automatic logic [QW+1:0] body_flit(input int c, input logic [31:0] v);
    body_flit = {(c == XW - 1) ? 2'b11 : 2'b10, v};
  endfunction

  task automatic send_pkt(input logic [7:0] px, input logic [7:0] py,
                          input logic [15:0] rmask, input logic exp_fd);
    logic [QW+1:0] ef;
    int idx = 0;
    int k = 0;
    @(negedge clk);
    for (int c = 0; c < XW; c++) data_i[c] = fl(c);
    valid_i = 1'b1;
    ready_i = 1'b1;
    #1;
    chk("idle_ready", ready_o, 1);
    chk("idle_valid", valid_o, 0);
    chk("idle_flit", flit_o, 0);
    while (idx <= XW && k < 32) begin
      @(negedge clk);
      valid_i = 1'b0;
      ready_i = rmask[k];
      #1;
      ef = (idx == 0) ? head_flit(px, py) : body_flit(idx - 1, fl(idx - 1));
      chk("pkt_valid", valid_o, 1);
      chk("pkt_flit", flit_o, ef);
      if (ready_i) idx++;
      k++;
    end
    @(negedge clk);
    ready_i = 1'b1;
    #1;
    chk("pkt_end_valid", valid_o, 0);
    chk("pkt_frame_done", frame_done_o, exp_fd);
  endtask

  typedef struct {
    logic [XW-1:0][QW-1:0] d;
    logic [7:0]            px;
    logic [7:0]            py;
  } pix_t;

  initial begin
    pix_t          q[$];
    pix_t          e;
    logic [QW+1:0] ef;
    int acc, pops, fd_cnt, pos, cyc, drain;
    logic [7:0] mx, my;

    rstn = 1'b0; valid_i = 1'b1; ready_i = 1'b0;
    for (int c = 0; c < XW; c++) data_i[c] = fl(c);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", ready_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_flit", flit_o, 0);
    chk("rst_frame_done", frame_done_o, 0);
    @(negedge clk);
    rstn = 1'b1; valid_i = 1'b0;

    send_pkt(8'd0, 8'd0, 16'hFFFF, 1'b0);
    send_pkt(8'd1, 8'd0, 16'hF8E0, 1'b0);
    send_pkt(8'd0, 8'd1, 16'hFFFF, 1'b0);
    send_pkt(8'd1, 8'd1, 16'hFFFF, 1'b1);

    // Streaming: five back-to-back pixels starting at frame origin
    @(negedge clk);
    for (int c = 0; c < XW; c++) data_i[c] = sv(0, c);
    valid_i = 1'b1; ready_i = 1'b1;
    for (int k = 0; k < 25; k++) begin
      int pkt, ps;
      pkt = k / 5; ps = k % 5;
      @(negedge clk);
      if (ps == 4) begin
        if (pkt < 4) for (int c = 0; c < XW; c++) data_i[c] = sv(pkt + 1, c);
        else valid_i = 1'b0;
      end
      #1;
      ef = (ps == 0) ? head_flit(8'(pkt % 2), 8'((pkt % 4) / 2)) : body_flit(ps - 1, sv(pkt, ps - 1));
      chk("stream_flit", flit_o, ef);
      chk("stream_frame_done", frame_done_o, (k == 20));
      chk("stream_ready", ready_o, (ps == 4));
    end
    @(negedge clk);
    #1;
    chk("stream_end_valid", valid_o, 0);

    // Reset in the middle of a packet
    @(negedge clk);
    for (int c = 0; c < XW; c++) data_i[c] = fl(c);
    valid_i = 1'b1; ready_i = 1'b1;
    @(negedge clk); valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst_valid", valid_o, 0);
    chk("midrst_flit", flit_o, 0);
    chk("midrst_ready", ready_o, 0);
    chk("midrst_frame_done", frame_done_o, 0);
    @(negedge clk);
    rstn = 1'b1;
    send_pkt(8'd0, 8'd0, 16'hFFFF, 1'b0);

    // Random handshakes on the 4x3 instance, three full frames
    @(negedge clk); rstn = 1'b0; valid_i = 1'b0;
    @(negedge clk); rstn = 1'b1;
    acc = 0; pops = 0; fd_cnt = 0; pos = 0; cyc = 0; drain = 0; mx = 0; my = 0;
    while ((acc < 36 || q.size() > 0 || drain < 4) && cyc < 4000) begin
      @(negedge clk);
      valid_i = (acc < 36) ? 1'($urandom_range(0, 1)) : 1'b0;
      ready_i = 1'($urandom_range(0, 1));
      for (int c = 0; c < XW; c++) data_i[c] = $urandom;
      #1;
      if (frame_done_o2) fd_cnt++;
      if (valid_o2 && ready_i) begin
        if (q.size() == 0) begin
          chk("rand_spurious_flit", valid_o2, 0);
        end else begin
          e  = q[0];
          ef = (pos == 0) ? head_flit(e.px, e.py) : body_flit(pos - 1, e.d[pos - 1]);
          chk("rand_flit", flit_o2, ef);
          pos++;
          if (pos == XW + 1) begin
            pos = 0;
            pops++;
            void'(q.pop_front());
          end
        end
      end
      if (valid_i && ready_o2) begin
        e.d = data_i; e.px = mx; e.py = my;
        q.push_back(e);
        acc++;
        if (mx == 8'd3) begin
          mx = 0;
          my = (my == 8'd2) ? 8'd0 : my + 8'd1;
        end else begin
          mx = mx + 8'd1;
        end
      end
      if (acc == 36 && q.size() == 0) drain++;
      cyc++;
    end
    if (cyc >= 4000) chk("rand_timeout_pending", q.size(), 0);
    chk("rand_packets", pops, 36);
    chk("rand_frame_done_count", fd_cnt, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
